// File: rtl/msgpu_bus_pkg.sv
// msgpu_bus_pkg: shared encodings, bus word type and transmitter FSM states for the MCU bus.
//   MCU_BUS_COMMAND / MCU_BUS_DATA : command_data line levels
//   mcu_bus_word_t                 : buffered entry {is_command, data[7:0]}
//   mcu_bus_tx_state_t             : transmitter FSM states
package msgpu_bus_pkg;
   localparam logic MCU_BUS_COMMAND = 1'b1;
   localparam logic MCU_BUS_DATA    = 1'b0;
   typedef struct packed {
      logic       is_command;
      logic [7:0] data;
   } mcu_bus_word_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_HIGH} mcu_bus_tx_state_t;
   function automatic logic command_data_level(input mcu_bus_word_t w);
      return w.is_command ? MCU_BUS_COMMAND : MCU_BUS_DATA;
   endfunction
endpackage

// File: rtl/mcu_bus_transmitter_if.sv
// mcu_bus_transmitter_if: byte stream in, parallel MCU bus out.
//   in_valid/in_ready/in_byte/in_is_command : upstream byte stream
//   busy                                    : byte buffered or on the bus
//   mcu_bus_clock/mcu_bus/mcu_bus_command_data : bus strobe, data and command flag
//   master : byte producer view; slave : transmitter view
interface mcu_bus_transmitter_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       in_is_command;
   logic       busy;
   logic       mcu_bus_clock;
   logic [7:0] mcu_bus;
   logic       mcu_bus_command_data;
   modport master (
      output in_valid, in_byte, in_is_command,
      input  in_ready, busy, mcu_bus_clock, mcu_bus, mcu_bus_command_data
   );
   modport slave (
      input  in_valid, in_byte, in_is_command,
      output in_ready, busy, mcu_bus_clock, mcu_bus, mcu_bus_command_data
   );
endinterface

// File: rtl/mcu_bus_tx_fifo.sv
// mcu_bus_tx_fifo: synchronous power-of-two FIFO of bus words with extra-MSB pointers.
//   clk, rst        : clock, synchronous active-high reset
//   push/wdata      : write port (caller guarantees not full)
//   pop/rdata/avail : read port; rdata is the head, valid while avail
//   full_next       : full flag for the next cycle (caller registers it)
//   any_next        : non-empty flag for the next cycle
module mcu_bus_tx_fifo
   import msgpu_bus_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  mcu_bus_word_t wdata,
   output mcu_bus_word_t rdata,
   output logic          avail,
   output logic          full_next,
   output logic          any_next
);
   localparam int AW = $clog2(DEPTH);
   mcu_bus_word_t mem [DEPTH];
   logic [AW:0] wr, rd, wr_seen, wr_n, rd_n;
   assign wr_n      = wr + {{AW{1'b0}}, push};
   assign rd_n      = rd + {{AW{1'b0}}, pop};
   assign full_next = (wr_n ^ rd_n) == {1'b1, {AW{1'b0}}};
   assign any_next  = wr_n != rd_n;
   // The reader compares against a one-cycle-old write pointer, so a written
   // entry becomes poppable one cycle after the write that stored it.
   assign avail     = wr_seen != rd;
   assign rdata     = mem[rd[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wr      <= '0;
         rd      <= '0;
         wr_seen <= '0;
      end else begin
         wr      <= wr_n;
         rd      <= rd_n;
         wr_seen <= wr;
      end
      if (push) mem[wr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/mcu_bus_transmitter.sv
// mcu_bus_transmitter: buffers command/data bytes and serialises them onto the MCU bus.
//   system_clock, reset : clock, synchronous active-high reset
//   bus (slave)         : byte stream in, busy, mcu_bus_clock/mcu_bus/mcu_bus_command_data out
//   CLOCK_DIV           : system clocks per bus-clock half period (1..255)
//   FIFO_DEPTH          : input FIFO depth, power of two >= 2
// Define MCU_BUS_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a
// single holding register buffers one byte.
module mcu_bus_transmitter
   import msgpu_bus_pkg::*;
#(
   parameter int CLOCK_DIV  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input logic                  system_clock,
   input logic                  reset,
   mcu_bus_transmitter_if.slave bus
);
   localparam int CW = $clog2(CLOCK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

   if (CLOCK_DIV < 1 || CLOCK_DIV > 255 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("mcu_bus_transmitter: illegal CLOCK_DIV or FIFO_DEPTH");
   end

   mcu_bus_word_t     in_word, head;
   mcu_bus_tx_state_t state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [7:0]        data, data_n;
   logic              push, pop, avail, full_next, any_next, done;
   logic              strobe, clk_n, cd, cd_n, ready, busy;

   assign in_word = {bus.in_is_command, bus.in_byte};
   assign push    = bus.in_valid & ready;
   assign done    = cnt == LAST;

`ifdef MCU_BUS_TX_FIFO_EN
   mcu_bus_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (system_clock),
      .rst       (reset),
      .push      (push),
      .pop       (pop),
      .wdata     (in_word),
      .rdata     (head),
      .avail     (avail),
      .full_next (full_next),
      .any_next  (any_next)
   );
`else
   mcu_bus_word_t hold;
   logic          hold_valid;
   // push implies the register was empty, so it can never coincide with a pop
   assign full_next = push | (hold_valid & ~pop);
   assign any_next  = full_next;
   assign head      = hold;
   assign avail     = hold_valid;
   always_ff @(posedge system_clock) begin
      if (reset) hold_valid <= 1'b0;
      else       hold_valid <= full_next;
      if (push) hold <= in_word;
   end
`endif

   always_comb begin
      state_n = state;
      cnt_n   = done ? '0 : cnt + 1'b1;
      clk_n   = strobe;
      data_n  = data;
      cd_n    = cd;
      pop     = 1'b0;
      case (state)
         TX_IDLE: begin
            cnt_n = '0;
            pop   = avail;
         end
         TX_SETUP: if (done) begin
            state_n = TX_HIGH;
            clk_n   = 1'b1;
         end
         default: if (done) begin
            state_n = TX_IDLE;
            clk_n   = 1'b0;
            pop     = avail;
         end
      endcase
      // A pop always starts a fresh setup phase with the new byte on the bus.
      if (pop) begin
         state_n = TX_SETUP;
         cnt_n   = '0;
         data_n  = head.data;
         cd_n    = command_data_level(head);
      end
   end

   always_ff @(posedge system_clock) begin
      if (reset) begin
         state  <= TX_IDLE;
         cnt    <= '0;
         strobe <= 1'b0;
         data   <= 8'h00;
         cd     <= MCU_BUS_DATA;
         busy   <= 1'b0;
         ready  <= 1'b1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         strobe <= clk_n;
         data   <= data_n;
         cd     <= cd_n;
         busy   <= any_next | (state_n != TX_IDLE);
         ready  <= ~full_next;
      end
   end

   assign bus.in_ready             = ready;
   assign bus.busy                 = busy;
   assign bus.mcu_bus_clock        = strobe;
   assign bus.mcu_bus              = data;
   assign bus.mcu_bus_command_data = cd;
endmodule

// File: tb/tb_mcu_bus_transmitter.sv
// tb_mcu_bus_transmitter: directed checks of mcu_bus_transmitter at several dividers.
module tb_mcu_bus_transmitter;
`ifdef MCU_BUS_TX_FIFO_EN
   localparam int E = 1;
`else
   localparam int E = 0;
`endif
   typedef struct {
      logic       v;
      logic [7:0] b;
      logic       c;
      logic       clk_e;
      logic [7:0] bus_e;
      logic       cd_e;
      logic       busy_e;
      logic       rdy_e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checks = 0;
   int         errors = 0;
   vec_t       tbl [14];
   logic [7:0] mb [3];

   always #5 clk = ~clk;

   mcu_bus_transmitter_if i4 ();
   mcu_bus_transmitter_if i2 ();
   mcu_bus_transmitter_if i8 ();
   mcu_bus_transmitter_if i1 ();

   mcu_bus_transmitter #(.CLOCK_DIV(4)) u4 (.system_clock(clk), .reset(rst), .bus(i4));
   mcu_bus_transmitter #(.CLOCK_DIV(2)) u2 (.system_clock(clk), .reset(rst), .bus(i2));
   mcu_bus_transmitter #(.CLOCK_DIV(8), .FIFO_DEPTH(4)) u8 (.system_clock(clk), .reset(rst), .bus(i8));
   mcu_bus_transmitter #(.CLOCK_DIV(1)) u1 (.system_clock(clk), .reset(rst), .bus(i1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int         sent, got, last, acc_total, first_drop, rises;
      logic       acc, pc;
      logic [7:0] prev_bus;
      i4.in_valid = 1'b0; i4.in_byte = 8'h00; i4.in_is_command = 1'b0;
      i2.in_valid = 1'b0; i2.in_byte = 8'h00; i2.in_is_command = 1'b0;
      i8.in_valid = 1'b0; i8.in_byte = 8'h00; i8.in_is_command = 1'b0;
      i1.in_valid = 1'b0; i1.in_byte = 8'h00; i1.in_is_command = 1'b0;
      mb[0] = 8'h11; mb[1] = 8'h22; mb[2] = 8'h33;
      for (int k = 0; k < 14; k++) begin
         tbl[k].v      = (k == 0);
         tbl[k].b      = 8'h3C;
         tbl[k].c      = 1'b1;
         tbl[k].clk_e  = (k >= 5 + E) && (k < 9 + E);
         tbl[k].bus_e  = (k >= 1 + E) ? 8'h3C : 8'h00;
         tbl[k].cd_e   = (k >= 1 + E);
         tbl[k].busy_e = (k < 9 + E);
         tbl[k].rdy_e  = (E == 1) || (k != 0);
      end

      repeat (3) tick;
      chk("reset_clk", i4.mcu_bus_clock, 0);
      chk("reset_bus", i4.mcu_bus, 8'h00);
      chk("reset_cd", i4.mcu_bus_command_data, 0);
      chk("reset_busy", i4.busy, 0);
      chk("reset_ready", i4.in_ready, 1);
      chk("reset_ready_u8", i8.in_ready, 1);
      rst = 1'b0;

      for (int k = 0; k < 14; k++) begin
         i4.in_valid = tbl[k].v;
         i4.in_byte = tbl[k].b;
         i4.in_is_command = tbl[k].c;
         tick;
         chk($sformatf("single%0d_clk", k), i4.mcu_bus_clock, tbl[k].clk_e);
         chk($sformatf("single%0d_bus", k), i4.mcu_bus, tbl[k].bus_e);
         chk($sformatf("single%0d_cd", k), i4.mcu_bus_command_data, tbl[k].cd_e);
         chk($sformatf("single%0d_busy", k), i4.busy, tbl[k].busy_e);
         chk($sformatf("single%0d_ready", k), i4.in_ready, tbl[k].rdy_e);
      end
      i4.in_valid = 1'b0;

      sent = 0; got = 0; last = -1; pc = 1'b0;
      i2.in_valid = 1'b1; i2.in_byte = 8'h00; i2.in_is_command = 1'b1;
      for (int t = 0; t < 300 && got < 16; t++) begin
         acc = i2.in_valid & i2.in_ready;
         tick;
         if (acc) begin
            sent++;
            chk("stream_ready_after_push", i2.in_ready, E);
            if (sent < 16) begin
               i2.in_byte = 8'(sent);
               i2.in_is_command = (sent % 2 == 0);
            end else i2.in_valid = 1'b0;
         end
         if (i2.mcu_bus_clock && !pc) begin
            chk("stream_byte", i2.mcu_bus, got);
            chk("stream_flag", i2.mcu_bus_command_data, (got % 2 == 0));
            if (last >= 0) chk("stream_period", t - last, 4);
            last = t;
            got++;
         end
         pc = i2.mcu_bus_clock;
      end
      chk("stream_count", got, 16);
      for (int t = 0; t < 50 && i2.busy; t++) tick;
      chk("stream_idle", i2.busy, 0);

      acc_total = 0; first_drop = -1; got = 0; pc = 1'b0; prev_bus = i8.mcu_bus;
      i8.in_valid = 1'b1; i8.in_byte = 8'h00; i8.in_is_command = 1'b0;
      for (int t = 0; t < 800; t++) begin
         acc = i8.in_valid & i8.in_ready;
         tick;
         if (acc) begin
            acc_total++;
            i8.in_byte = 8'(acc_total);
         end
         if (first_drop < 0 && !i8.in_ready) begin
            first_drop = acc_total;
            chk("full_accepts_before_drop", acc_total, E ? 5 : 1);
         end
         if (i8.mcu_bus !== prev_bus) chk("full_ready_after_pop", i8.in_ready, 1);
         if (i8.mcu_bus_clock && !pc) begin
            chk("full_byte", i8.mcu_bus, got);
            got++;
         end
         prev_bus = i8.mcu_bus;
         pc = i8.mcu_bus_clock;
         if (got >= 6) i8.in_valid = 1'b0;
         if (!i8.in_valid && !i8.busy) break;
      end
      chk("full_drop_seen", first_drop >= 0, 1);
      chk("full_no_loss", got, acc_total);
      chk("full_idle", i8.busy, 0);

      sent = 0; got = 0; last = -1; pc = 1'b0; prev_bus = i1.mcu_bus;
      i1.in_valid = 1'b1; i1.in_byte = mb[0]; i1.in_is_command = 1'b1;
      for (int t = 0; t < 100; t++) begin
         acc = i1.in_valid & i1.in_ready;
         tick;
         if (acc) begin
            sent++;
            if (sent < 3) i1.in_byte = mb[sent];
            else i1.in_valid = 1'b0;
         end
         if (i1.mcu_bus !== prev_bus) chk("min_change_on_fall", i1.mcu_bus_clock, 0);
         if (pc) chk("min_high_one_cycle", i1.mcu_bus_clock, 0);
         if (i1.mcu_bus_clock && !pc) begin
            if (got < 3) chk("min_byte", i1.mcu_bus, mb[got]);
            if (last >= 0) chk("min_period", t - last, 2);
            last = t;
            got++;
         end
         prev_bus = i1.mcu_bus;
         pc = i1.mcu_bus_clock;
         if (!i1.in_valid && !i1.busy) break;
      end
      chk("min_rises", got, 3);

      sent = 0;
      i4.in_valid = 1'b1; i4.in_byte = 8'hA5; i4.in_is_command = 1'b1;
      for (int t = 0; t < 20 && sent < 2; t++) begin
         acc = i4.in_valid & i4.in_ready;
         tick;
         if (acc) begin
            sent++;
            i4.in_byte = 8'h5A;
            i4.in_is_command = 1'b0;
         end
      end
      i4.in_valid = 1'b0;
      chk("rst_pushes", sent, 2);
      for (int t = 0; t < 40 && !i4.mcu_bus_clock; t++) tick;
      chk("rst_in_high", i4.mcu_bus_clock, 1);
      chk("rst_bus_before", i4.mcu_bus, 8'hA5);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("rst%0d_clk", k), i4.mcu_bus_clock, 0);
         chk($sformatf("rst%0d_bus", k), i4.mcu_bus, 8'h00);
         chk($sformatf("rst%0d_cd", k), i4.mcu_bus_command_data, 0);
         chk($sformatf("rst%0d_busy", k), i4.busy, 0);
         chk($sformatf("rst%0d_ready", k), i4.in_ready, 1);
      end
      rst = 1'b0;
      rises = 0; pc = 1'b0;
      for (int t = 0; t < 40; t++) begin
         tick;
         if (i4.mcu_bus_clock && !pc) rises++;
         pc = i4.mcu_bus_clock;
      end
      chk("rst_no_strobe", rises, 0);
      chk("rst_idle_busy", i4.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
